pc_sequencer: RTL and testbench

- Next-PC controller for the RV32I core. It selects the value the PC register loads each cycle: sequential, branch, jump, trap or hold.
- Drives the PC register's next-value input, which has no enable, so a hold is produced by feeding back the current PC.
- Runs a small FSM for boot, normal run, post-redirect flush bubbles and halt.
- Sits between decode/execute (redirect sources) and the PC register / instruction fetch.

---
 rtl/pc_seq_pkg.sv | 33 +++
 rtl/pc_seq_if.sv | 37 +++
 rtl/pc_next_mux.sv | 52 +++++
 rtl/pc_sequencer.sv | 146 ++++++++++++++
 tb/tb_pc_sequencer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// ----------------------------------------------------------------------------
// pc_seq_pkg
// Shared types and constants for the next-PC sequencer.
//   pc_seq_state_t : sequencer FSM states (BOOT, RUN, FLUSH, HALT)
//   pc_src_t       : selector for the next-PC multiplexer
//   PC_INC         : sequential fetch stride
//   is_misaligned  : true when an address is not word aligned
// ----------------------------------------------------------------------------
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH,
        HALT
    } pc_seq_state_t;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_HOLD,
        SRC_BRANCH,
        SRC_JUMP,
        SRC_RESET,
        SRC_TRAP
    } pc_src_t;

    localparam logic [31:0] PC_INC = 32'd4;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr & 32'h0000_0003) != 32'h0;
    endfunction

endpackage

// File: rtl/pc_seq_if.sv
// ----------------------------------------------------------------------------
// pc_seq_if
// Bundle between the core (redirect sources, PC register, fetch) and the
// next-PC sequencer.
//   master : core side; drives pc_cur, stall, redirects, halt/resume
//   slave  : sequencer side; drives pc_next, fetch_valid, flush, halted,
//            trap_taken
// ----------------------------------------------------------------------------
interface pc_seq_if;

    logic [31:0] pc_cur;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt;
    logic        resume;
    logic [31:0] pc_next;
    logic        fetch_valid;
    logic        flush;
    logic        halted;
    logic        trap_taken;

    modport master (
        output pc_cur, stall, branch_taken, branch_target,
               jump, jump_target, halt, resume,
        input  pc_next, fetch_valid, flush, halted, trap_taken
    );

    modport slave (
        input  pc_cur, stall, branch_taken, branch_target,
               jump, jump_target, halt, resume,
        output pc_next, fetch_valid, flush, halted, trap_taken
    );

endinterface

// File: rtl/pc_next_mux.sv
// ----------------------------------------------------------------------------
// pc_next_mux
// Purely combinational next-PC selector.
//   src           : which source feeds the PC register
//   pc_cur        : current PC (hold / sequential base)
//   branch_target : branch destination
//   jump_target   : JAL/JALR destination
//   pc_next       : value for the PC register's next-value input
// Build option PC_SEQ_MISALIGN_TRAP_EN: when defined, targets pass through
// untouched (misaligned ones are diverted to SRC_TRAP upstream); otherwise
// target bits [1:0] are forced to zero.
// ----------------------------------------------------------------------------
module pc_next_mux
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  pc_src_t     src,
    input  logic [31:0] pc_cur,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    output logic [31:0] pc_next
);

    logic [31:0] branch_aligned;
    logic [31:0] jump_aligned;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    assign branch_aligned = branch_target;
    assign jump_aligned   = jump_target;
`else
    assign branch_aligned = branch_target & ~32'h0000_0003;
    assign jump_aligned   = jump_target   & ~32'h0000_0003;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        pc_next = pc_cur;
        unique case (src)
            SRC_SEQ:    pc_next = pc_cur + PC_INC;  // wraps naturally at 2^32
            SRC_HOLD:   pc_next = pc_cur;
            SRC_BRANCH: pc_next = branch_aligned;
            SRC_JUMP:   pc_next = jump_aligned;
            SRC_RESET:  pc_next = RESET_VECTOR;
            SRC_TRAP:   pc_next = TRAP_VECTOR;
            default:    pc_next = pc_cur;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Next-PC controller for the RV32I core. Chooses sequential, branch, jump,
// trap or hold for the PC register (which has no enable, so hold feeds back
// pc_cur), and runs the BOOT / RUN / FLUSH / HALT FSM.
// Ports:
//   clk  : core clock, rising edge
//   rst  : synchronous reset, active low
//   bus  : pc_seq_if.slave (pc_cur, stall, redirects, halt/resume in;
//          pc_next, fetch_valid, flush, halted, trap_taken out)
// Outputs are combinational from state and inputs and are forced to their
// reset values while rst is low.
// Build option PC_SEQ_MISALIGN_TRAP_EN: a redirect to a non-word-aligned
// target goes to TRAP_VECTOR with a trap_taken pulse instead of being masked.
// ----------------------------------------------------------------------------
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic     clk,
    input  logic     rst,
    pc_seq_if.slave  bus
);

    // Counter holds the remaining bubbles minus one; 0 means "last bubble".
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    pc_seq_state_t state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;

    logic    redirect;
    logic    redirect_trap;
    pc_src_t redirect_src;
    pc_src_t src;

    // jump outranks branch_taken when both fire.
    assign redirect     = bus.jump | bus.branch_taken;
    assign redirect_src = bus.jump ? SRC_JUMP : SRC_BRANCH;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    logic [31:0] redirect_target;
    assign redirect_target = bus.jump ? bus.jump_target : bus.branch_target;
    assign redirect_trap   = redirect && is_misaligned(redirect_target);
`else
    assign redirect_trap   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            state_q <= BOOT;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (bus.halt) begin
                    state_d = HALT;
                end else if (redirect) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_INIT;
                end
            end
            FLUSH: begin
                // Redirects here come from squashed instructions and are
                // ignored; a stall freezes the bubble count.
                if (bus.halt) begin
                    state_d = HALT;
                end else if (!bus.stall) begin
                    if (cnt_q == 3'd0) state_d = RUN;
                    else               cnt_d   = cnt_q - 3'd1;
                end
            end
            HALT: begin
                if (bus.resume && !bus.halt) state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
    end

    // Output logic.
    always_comb begin
        src             = SRC_HOLD;
        bus.fetch_valid = 1'b0;
        bus.flush       = 1'b0;
        bus.halted      = 1'b0;
        bus.trap_taken  = 1'b0;
        if (!rst) begin
            src = SRC_RESET;
        end else begin
            unique case (state_q)
                BOOT: src = SRC_RESET;
                RUN: begin
                    bus.fetch_valid = 1'b1;
                    if (bus.halt) begin
                        src = SRC_HOLD;
                    end else if (redirect) begin
                        bus.flush = 1'b1;
                        if (redirect_trap) begin
                            src            = SRC_TRAP;
                            bus.trap_taken = 1'b1;
                        end else begin
                            src = redirect_src;
                        end
                    end else if (bus.stall) begin
                        src = SRC_HOLD;
                    end else begin
                        src = SRC_SEQ;
                    end
                end
                FLUSH: src = (bus.halt || bus.stall) ? SRC_HOLD : SRC_SEQ;
                HALT: begin
                    bus.halted = 1'b1;
                    src        = SRC_HOLD;
                end
                default: src = SRC_RESET;
            endcase
        end
    end

    pc_next_mux #(
        .RESET_VECTOR (RESET_VECTOR),
        .TRAP_VECTOR  (TRAP_VECTOR)
    ) u_pc_next_mux (
        .src           (src),
        .pc_cur        (bus.pc_cur),
        .branch_target (bus.branch_target),
        .jump_target   (bus.jump_target),
        .pc_next       (bus.pc_next)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed, self-checking bench for pc_sequencer. Inputs change 1 time unit
// after each rising edge; outputs are sampled 1 unit later, mid-cycle.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pc_sequencer;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    pc_seq_if bus();

    pc_sequencer #(
        .RESET_VECTOR (32'h0000_0000),
        .FLUSH_CYCLES (2),
        .TRAP_VECTOR  (32'h0000_0100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Checks pc_next, fetch_valid, flush and halted in one call.
    task automatic expect_out(input string tag, input logic [31:0] pc,
                              input logic fv, input logic fl, input logic hl);
        #1;
        check({tag, ".pc_next"},     bus.pc_next,            pc);
        check({tag, ".fetch_valid"}, 32'(bus.fetch_valid),   32'(fv));
        check({tag, ".flush"},       32'(bus.flush),         32'(fl));
        check({tag, ".halted"},      32'(bus.halted),        32'(hl));
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.jump          = 1'b0;
        bus.halt          = 1'b0;
        bus.resume        = 1'b0;
        bus.branch_target = 32'h0;
        bus.jump_target   = 32'h0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        bus.pc_cur   = 32'h0000_1234;
        clear_inputs();

        // Reset held for two cycles: outputs at reset values.
        next_cycle();
        next_cycle();
        expect_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        check("reset.trap_taken", 32'(bus.trap_taken), 32'h0);

        // Release: one BOOT cycle, then sequential run.
        rst = 1'b1;
        bus.pc_cur = 32'h0;
        expect_out("boot", 32'h0, 1'b0, 1'b0, 1'b0);
        next_cycle(); bus.pc_cur = 32'h0; expect_out("run0", 32'h4, 1'b1, 1'b0, 1'b0);
        next_cycle(); bus.pc_cur = 32'h4; expect_out("run1", 32'h8, 1'b1, 1'b0, 1'b0);
        next_cycle(); bus.pc_cur = 32'h8; expect_out("run2", 32'hC, 1'b1, 1'b0, 1'b0);

        // Taken branch: redirect, two bubbles, fetch resumes at 0x208.
        next_cycle();
        bus.pc_cur = 32'h40; bus.branch_taken = 1'b1; bus.branch_target = 32'h200;
        expect_out("br", 32'h200, 1'b1, 1'b1, 1'b0);
        next_cycle(); clear_inputs(); bus.pc_cur = 32'h200;
        expect_out("br.bub0", 32'h204, 1'b0, 1'b0, 1'b0);
        next_cycle(); bus.pc_cur = 32'h204;
        expect_out("br.bub1", 32'h208, 1'b0, 1'b0, 1'b0);
        next_cycle(); bus.pc_cur = 32'h208;
        expect_out("br.resume", 32'h20C, 1'b1, 1'b0, 1'b0);

        // jump beats branch; a jump inside FLUSH is ignored.
        next_cycle();
        bus.jump = 1'b1; bus.jump_target = 32'h80;
        bus.branch_taken = 1'b1; bus.branch_target = 32'h300;
        expect_out("prio", 32'h80, 1'b1, 1'b1, 1'b0);
        next_cycle(); clear_inputs(); bus.pc_cur = 32'h80;
        bus.jump = 1'b1; bus.jump_target = 32'h400;
        expect_out("flush.jump_ign", 32'h84, 1'b0, 1'b0, 1'b0);
        next_cycle(); clear_inputs(); bus.pc_cur = 32'h84;
        expect_out("flush.bub1", 32'h88, 1'b0, 1'b0, 1'b0);
        next_cycle(); bus.pc_cur = 32'h88;
        expect_out("flush.done", 32'h8C, 1'b1, 1'b0, 1'b0);

        // Redirect with stall: redirect wins, stall then freezes FLUSH.
        bus.jump = 1'b1; bus.jump_target = 32'h500; bus.stall = 1'b1;
        expect_out("rd_stall", 32'h500, 1'b1, 1'b1, 1'b0);
        next_cycle(); clear_inputs(); bus.pc_cur = 32'h500; bus.stall = 1'b1;
        expect_out("rd_stall.hold", 32'h500, 1'b0, 1'b0, 1'b0);
        next_cycle(); bus.stall = 1'b0;
        expect_out("rd_stall.bub0", 32'h504, 1'b0, 1'b0, 1'b0);
        next_cycle(); bus.pc_cur = 32'h504;
        expect_out("rd_stall.bub1", 32'h508, 1'b0, 1'b0, 1'b0);
        next_cycle(); bus.pc_cur = 32'h508;
        expect_out("rd_stall.run", 32'h50C, 1'b1, 1'b0, 1'b0);

        // Stall in RUN holds the PC; then wrap at the top of the space.
        bus.pc_cur = 32'h10; bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_out($sformatf("stall%0d", i), 32'h10, 1'b1, 1'b0, 1'b0);
            next_cycle();
        end
        bus.stall = 1'b0; bus.pc_cur = 32'hFFFF_FFFC;
        expect_out("wrap", 32'h0, 1'b1, 1'b0, 1'b0);

        // Halt, hold five cycles, halt+resume stays, then resume.
        next_cycle();
        bus.pc_cur = 32'h24; bus.halt = 1'b1;
        expect_out("halt.req", 32'h24, 1'b1, 1'b0, 1'b0);
        next_cycle(); bus.halt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_out($sformatf("halt.hold%0d", i), 32'h24, 1'b0, 1'b0, 1'b1);
            next_cycle();
        end
        bus.halt = 1'b1; bus.resume = 1'b1;
        expect_out("halt.both", 32'h24, 1'b0, 1'b0, 1'b1);
        next_cycle(); bus.halt = 1'b0;
        expect_out("halt.resume", 32'h24, 1'b0, 1'b0, 1'b1);
        next_cycle(); bus.resume = 1'b0;
        expect_out("halt.run", 32'h28, 1'b1, 1'b0, 1'b0);

        // Halt requested during FLUSH is honoured.
        bus.jump = 1'b1; bus.jump_target = 32'h600;
        next_cycle(); clear_inputs(); bus.pc_cur = 32'h600; bus.halt = 1'b1;
        expect_out("flush.halt", 32'h600, 1'b0, 1'b0, 1'b0);
        next_cycle(); bus.halt = 1'b0;
        expect_out("flush.halted", 32'h600, 1'b0, 1'b0, 1'b1);

        // Reset during HALT returns to BOOT.
        rst = 1'b0;
        expect_out("halt.rst", 32'h0, 1'b0, 1'b0, 1'b0);
        next_cycle(); rst = 1'b1; bus.pc_cur = 32'h0;
        expect_out("halt.rst.boot", 32'h0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        expect_out("halt.rst.run", 32'h4, 1'b1, 1'b0, 1'b0);

        // Misaligned jump target.
        bus.pc_cur = 32'h30; bus.jump = 1'b1; bus.jump_target = 32'h102;
        expect_out("misalign", 32'h100, 1'b1, 1'b1, 1'b0);
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        check("misalign.trap_taken", 32'(bus.trap_taken), 32'h1);
`else
        check("misalign.trap_taken", 32'(bus.trap_taken), 32'h0);
`endif
        next_cycle(); clear_inputs(); bus.pc_cur = 32'h100;
        expect_out("misalign.bub0", 32'h104, 1'b0, 1'b0, 1'b0);
        check("misalign.trap_pulse", 32'(bus.trap_taken), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
